// File: rtl/gpio_port_if.sv
// Bus bundle between the interconnect and the GPIO port: address, write data,
// write strobe going in, registered read data coming back.
interface gpio_port_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             we_gpio;
  logic [WIDTH-1:0] rdata_gpio;

  modport master (
    output addr,
    output wdata,
    output we_gpio,
    input  rdata_gpio
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we_gpio,
    output rdata_gpio
  );
endinterface

// File: rtl/gpio_port.sv
// GPIO port: OUT/DIR/IN/RISE_EN/FALL_EN/STATUS register block with a 2-flop
// input synchronizer, per-pin edge detection and a level interrupt.
// Edge detection is held off for a few cycles after reset (PRIME state) so
// that pins already high when reset lifts are not mistaken for rising edges.
module gpio_port #(
  parameter int WIDTH    = 32,
  parameter int OFFS_LSB = 2
) (
  input  logic             clk,
  input  logic             rst,
  gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic {
    PRIME = 1'b0,
    ARMED = 1'b1
  } armState_e;

  localparam logic [2:0] IDX_OUT    = 3'd0;
  localparam logic [2:0] IDX_DIR    = 3'd1;
  localparam logic [2:0] IDX_IN     = 3'd2;
  localparam logic [2:0] IDX_RISE   = 3'd3;
  localparam logic [2:0] IDX_FALL   = 3'd4;
  localparam logic [2:0] IDX_STATUS = 3'd5;

  // Architectural registers
  logic [WIDTH-1:0] outReg_q,  outReg_d;
  logic [WIDTH-1:0] dirReg_q,  dirReg_d;
  logic [WIDTH-1:0] riseEn_q,  riseEn_d;
  logic [WIDTH-1:0] fallEn_q,  fallEn_d;
  logic [WIDTH-1:0] status_q,  status_d;
  logic [WIDTH-1:0] rdata_q,   rdata_d;

  // Synchronizer chain; s2 is the IN register, s3 its previous value
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;

  // Arm FSM
  armState_e armState_q, armState_d;
  logic [1:0] armCnt_q, armCnt_d;
  logic       armed;

  logic [2:0]       regIdx;
  logic [WIDTH-1:0] riseBits;
  logic [WIDTH-1:0] fallBits;
  logic [WIDTH-1:0] setBits;
  logic [WIDTH-1:0] clrBits;
  logic             unusedAddrBits;

  assign regIdx = bus.addr[OFFS_LSB+2:OFFS_LSB];

  // Only three address bits are decoded; the rest are folded here on purpose
  assign unusedAddrBits = ^bus.addr;

  // Arm FSM next state: count out the synchronizer fill time, then stay armed
  always_comb begin
    armState_d = armState_q;
    armCnt_d   = armCnt_q;
    armed      = 1'b0;
    case (armState_q)
      PRIME: begin
        if (armCnt_q == 2'd2) begin
          armState_d = ARMED;
        end else begin
          armCnt_d = armCnt_q + 2'd1;
        end
      end
      ARMED: begin
        armed = 1'b1;
      end
      default: begin
        armState_d = PRIME;
        armCnt_d   = 2'd0;
      end
    endcase
  end

  // Edge detection on the synchronized pins, gated by the arm state
  always_comb begin
    riseBits = s2_q & ~s3_q;
    fallBits = ~s2_q & s3_q;
    setBits  = '0;
    if (armed) begin
      setBits = (riseBits & riseEn_q) | (fallBits & fallEn_q);
    end
  end

  // Register writes, W1C on STATUS (a same-cycle set beats the clear), read mux
  always_comb begin
    outReg_d = outReg_q;
    dirReg_d = dirReg_q;
    riseEn_d = riseEn_q;
    fallEn_d = fallEn_q;
    clrBits  = '0;
    if (bus.we_gpio) begin
      case (regIdx)
        IDX_OUT:    outReg_d = bus.wdata;
        IDX_DIR:    dirReg_d = bus.wdata;
        IDX_RISE:   riseEn_d = bus.wdata;
        IDX_FALL:   fallEn_d = bus.wdata;
        IDX_STATUS: clrBits  = bus.wdata;
        default:    clrBits  = '0;
      endcase
    end
    status_d = (status_q & ~clrBits) | setBits;

    rdata_d = '0;
    case (regIdx)
      IDX_OUT:    rdata_d = outReg_q;
      IDX_DIR:    rdata_d = dirReg_q;
      IDX_IN:     rdata_d = s2_q;
      IDX_RISE:   rdata_d = riseEn_q;
      IDX_FALL:   rdata_d = fallEn_q;
      IDX_STATUS: rdata_d = status_q;
      default:    rdata_d = '0;
    endcase
  end

  // State update; reset discards everything including a write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      outReg_q   <= '0;
      dirReg_q   <= '0;
      riseEn_q   <= '0;
      fallEn_q   <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      armCnt_q   <= 2'd0;
      armState_q <= PRIME;
    end else begin
      outReg_q   <= outReg_d;
      dirReg_q   <= dirReg_d;
      riseEn_q   <= riseEn_d;
      fallEn_q   <= fallEn_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      s1_q       <= gpio_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      armCnt_q   <= armCnt_d;
      armState_q <= armState_d;
    end
  end

  assign bus.rdata_gpio = rdata_q;
  assign gpio_out       = outReg_q & dirReg_q;
  assign gpio_oe        = dirReg_q;
  assign irq            = |status_q;

endmodule

// File: tb/tb_gpio_port.sv
// Testbench for gpio_port: directed scenarios followed by random traffic,
// everything compared cycle by cycle against a behavioural model.
module tb_gpio_port;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] gpioIn;
  logic [WIDTH-1:0] gpioOut;
  logic [WIDTH-1:0] gpioOe;
  logic             irq;

  int testsRun    = 0;
  int testsFailed = 0;

  // Behavioural model state
  logic [31:0] mOut  = '0;
  logic [31:0] mDir  = '0;
  logic [31:0] mRise = '0;
  logic [31:0] mFall = '0;
  logic [31:0] mStat = '0;
  logic [31:0] mRd   = '0;
  logic [31:0] pinSamples [3];   // [0] newest sample of the pins, [1] = IN, [2] = IN one cycle earlier
  int          edgesSinceReset = 0;
  logic [31:0] curPins = '0;

  gpio_port_if #(.WIDTH(WIDTH)) bus ();

  gpio_port #(
    .WIDTH    (WIDTH),
    .OFFS_LSB (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .gpio_in  (gpioIn),
    .gpio_out (gpioOut),
    .gpio_oe  (gpioOe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input int idx);
    case (idx)
      0:       return mOut;
      1:       return mDir;
      2:       return pinSamples[1];
      3:       return mRise;
      4:       return mFall;
      5:       return mStat;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one rising edge with the inputs that were applied
  task automatic updateModel(input logic r, input int idx, input logic we,
                             input logic [31:0] wd, input logic [31:0] pins);
    logic [31:0] inNow, inPrev, setBits, clrBits;
    if (r) begin
      mOut = '0; mDir = '0; mRise = '0; mFall = '0; mStat = '0; mRd = '0;
      for (int k = 0; k < 3; k++) pinSamples[k] = '0;
      edgesSinceReset = 0;
    end else begin
      inNow   = pinSamples[1];
      inPrev  = pinSamples[2];
      setBits = '0;
      if (edgesSinceReset >= 3) begin
        setBits = (inNow & ~inPrev & mRise) | (~inNow & inPrev & mFall);
      end
      mRd     = modelRead(idx);
      clrBits = '0;
      if (we) begin
        case (idx)
          0: mOut  = wd;
          1: mDir  = wd;
          3: mRise = wd;
          4: mFall = wd;
          5: clrBits = wd;
          default: ;
        endcase
      end
      mStat = (mStat & ~clrBits) | setBits;
      pinSamples[2] = pinSamples[1];
      pinSamples[1] = pinSamples[0];
      pinSamples[0] = pins;
      edgesSinceReset++;
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare shortly after
  task automatic applyStimulus(input logic r, input int idx, input logic we,
                               input logic [31:0] wd, input logic [31:0] pins);
    logic [31:0] a;
    a       = $urandom;
    a[4:2]  = idx[2:0];
    rst         = r;
    bus.addr    = a;
    bus.wdata   = wd;
    bus.we_gpio = we;
    gpioIn      = pins;
    curPins     = pins;
    @(posedge clk);
    updateModel(r, idx, we, wd, pins);
    #1;
    checkOutput("gpio_out", gpioOut, mOut & mDir);
    checkOutput("gpio_oe", gpioOe, mDir);
    checkOutput("irq", {31'b0, irq}, {31'b0, |mStat});
    checkOutput("rdata", bus.rdata_gpio, mRd);
  endtask

  task automatic idleCycles(input int n, input int idx);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, idx, 1'b0, 32'h0, curPins);
  endtask

  initial begin
    logic        r, we;
    int          idx;
    logic [31:0] wd;

    for (int k = 0; k < 3; k++) pinSamples[k] = '0;
    rst = 1'b1; bus.addr = '0; bus.wdata = '0; bus.we_gpio = 1'b0; gpioIn = '0;

    // Reset, with a write strobe that must be ignored
    applyStimulus(1'b1, 0, 1'b1, 32'hDEAD_BEEF, 32'h0);
    applyStimulus(1'b1, 0, 1'b1, 32'hDEAD_BEEF, 32'h0);
    checkOutput("rst_gpio_out", gpioOut, 32'h0);
    checkOutput("rst_gpio_oe", gpioOe, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_rdata", bus.rdata_gpio, 32'h0);

    // OUT/DIR writes and readback
    applyStimulus(1'b0, 0, 1'b1, 32'h0000_00FF, 32'h0);
    applyStimulus(1'b0, 1, 1'b1, 32'h0000_000F, 32'h0);
    checkOutput("out_and_dir", gpioOut, 32'h0000_000F);
    checkOutput("oe_is_dir", gpioOe, 32'h0000_000F);
    applyStimulus(1'b0, 0, 1'b0, 32'h0, 32'h0);
    checkOutput("read_out", bus.rdata_gpio, 32'h0000_00FF);

    // IN latency, reserved reads, write to IN ignored
    applyStimulus(1'b0, 2, 1'b0, 32'h0, 32'hA5A5_A5A5);
    applyStimulus(1'b0, 2, 1'b0, 32'h0, 32'hA5A5_A5A5);
    applyStimulus(1'b0, 2, 1'b0, 32'h0, 32'hA5A5_A5A5);
    checkOutput("read_in", bus.rdata_gpio, 32'hA5A5_A5A5);
    applyStimulus(1'b0, 6, 1'b0, 32'h0, 32'hA5A5_A5A5);
    checkOutput("read_rsvd6", bus.rdata_gpio, 32'h0);
    applyStimulus(1'b0, 7, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
    checkOutput("read_rsvd7", bus.rdata_gpio, 32'h0);
    applyStimulus(1'b0, 2, 1'b1, 32'h0, 32'hA5A5_A5A5);
    applyStimulus(1'b0, 2, 1'b0, 32'h0, 32'hA5A5_A5A5);
    checkOutput("in_write_ignored", bus.rdata_gpio, 32'hA5A5_A5A5);
    checkOutput("rsvd_write_ignored", gpioOut, 32'h0000_000F);

    // Rising edge on pin 0 sets STATUS[0]; W1C clears it
    applyStimulus(1'b0, 0, 1'b0, 32'h0, 32'h0);
    idleCycles(3, 0);
    applyStimulus(1'b0, 3, 1'b1, 32'h1, 32'h0);
    applyStimulus(1'b0, 5, 1'b0, 32'h0, 32'h1);
    applyStimulus(1'b0, 5, 1'b0, 32'h0, 32'h1);
    applyStimulus(1'b0, 5, 1'b0, 32'h0, 32'h1);
    checkOutput("rise_irq", {31'b0, irq}, 32'h1);
    applyStimulus(1'b0, 5, 1'b0, 32'h0, 32'h1);
    checkOutput("rise_status", bus.rdata_gpio, 32'h1);
    applyStimulus(1'b0, 5, 1'b1, 32'h1, 32'h1);
    checkOutput("w1c_irq", {31'b0, irq}, 32'h0);

    // Falling edge on pin 1 whose set coincides with a W1C of the same bit
    applyStimulus(1'b0, 4, 1'b1, 32'h2, 32'h1);
    applyStimulus(1'b0, 0, 1'b0, 32'h0, 32'h3);
    idleCycles(3, 0);
    applyStimulus(1'b0, 0, 1'b0, 32'h0, 32'h1);
    applyStimulus(1'b0, 0, 1'b0, 32'h0, 32'h1);
    applyStimulus(1'b0, 5, 1'b1, 32'h2, 32'h1);
    checkOutput("set_beats_clr_irq", {31'b0, irq}, 32'h1);
    applyStimulus(1'b0, 5, 1'b0, 32'h0, 32'h1);
    checkOutput("set_beats_clr", bus.rdata_gpio, 32'h2);

    // Build STATUS=0x3 and OUT=0x5, then reset mid-operation
    applyStimulus(1'b0, 0, 1'b0, 32'h0, 32'h0);
    idleCycles(3, 0);
    applyStimulus(1'b0, 0, 1'b0, 32'h0, 32'h1);
    idleCycles(2, 0);
    applyStimulus(1'b0, 0, 1'b1, 32'h5, 32'h1);
    checkOutput("out5", gpioOut, 32'h5);
    applyStimulus(1'b0, 5, 1'b0, 32'h0, 32'h1);
    checkOutput("status3", bus.rdata_gpio, 32'h3);
    applyStimulus(1'b1, 5, 1'b1, 32'hFF, 32'h1);
    checkOutput("midrst_gpio_out", gpioOut, 32'h0);
    checkOutput("midrst_gpio_oe", gpioOe, 32'h0);
    checkOutput("midrst_irq", {31'b0, irq}, 32'h0);
    checkOutput("midrst_rdata", bus.rdata_gpio, 32'h0);

    // Pins high through reset with all rise enables armed early: no spurious STATUS
    applyStimulus(1'b1, 0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 5, 1'b0, 32'h0, 32'hFFFF_FFFF);
      checkOutput("held_high_irq", {31'b0, irq}, 32'h0);
    end
    checkOutput("held_high_status", bus.rdata_gpio, 32'h0);
    applyStimulus(1'b0, 3, 1'b0, 32'h0, 32'hFFFF_FFFF);
    checkOutput("prime_write_kept", bus.rdata_gpio, 32'hFFFF_FFFF);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      idx = $urandom_range(0, 7);
      we  = ($urandom_range(0, 2) == 0);
      wd  = $urandom;
      if ($urandom_range(0, 3) == 0) curPins = curPins ^ ($urandom & $urandom);
      applyStimulus(r, idx, we, wd, curPins);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
